// File: rtl/top_result_sink.sv
// rtl/top_result_sink.sv - terminal sink that buffers one output tensor and exposes it on a registered read port
// Optional feature macro: TOP_RESULT_SINK_AUTO_RELEASE_EN (a read of the last element in FULL releases the buffer)
module top_result_sink #(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 10,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int COUNT_WIDTH                 = 8,
  localparam int PAR    = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1,
  localparam int DEPTH  = DATA_IN_0_TENSOR_SIZE_DIM_0 * DATA_IN_0_TENSOR_SIZE_DIM_1,
  localparam int BEATS  = DEPTH / PAR,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0 [PAR],
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  input  logic                             rd_en,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [DATA_IN_0_PRECISION_0-1:0] rd_data,
  output logic                             rd_valid,
  input  logic                             clear,
  output logic                             frame_done,
  output logic [COUNT_WIDTH-1:0]           frame_count
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

  state_t                           state, state_d;
  logic [BW-1:0]                    beat_cnt, beat_d;
  logic [COUNT_WIDTH-1:0]           count_d;
  logic                             wr_en;
  logic                             auto_release;
  logic [ADDR_W-1:0]                wr_idx [PAR];
  logic [DATA_IN_0_PRECISION_0-1:0] mem [DEPTH];

`ifdef TOP_RESULT_SINK_AUTO_RELEASE_EN
  assign auto_release = rd_en && (rd_addr == LAST_ADDR);
`else
  assign auto_release = 1'b0;
`endif

  // Ready depends on state alone so upstream never sees a valid->ready loop.
  assign data_in_0_ready = (state == FILL);
  assign frame_done      = (state == FULL);

  always_comb begin
    state_d = state;
    beat_d  = beat_cnt;
    count_d = frame_count;
    wr_en   = 1'b0;
    case (state)
      IDLE: state_d = FILL;
      FILL: begin
        wr_en = data_in_0_valid;
        if (clear) begin
          beat_d = '0;
        end else if (data_in_0_valid) begin
          if (beat_cnt == LAST_BEAT) begin
            state_d = FULL;
            beat_d  = '0;
            count_d = frame_count + COUNT_WIDTH'(1);
          end else begin
            beat_d = beat_cnt + BW'(1);
          end
        end
      end
      FULL: if (clear || auto_release) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < PAR; i++) begin
      wr_idx[i] = ADDR_W'(beat_cnt) * ADDR_W'(PAR) + ADDR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      frame_count <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      state       <= state_d;
      beat_cnt    <= beat_d;
      frame_count <= count_d;
      rd_valid    <= rd_en;
      // Nonblocking read sees the pre-write contents on a same-index collision.
      if (rd_en) rd_data <= (rd_addr > LAST_ADDR) ? '0 : mem[rd_addr];
    end
  end

  // Buffer storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < PAR; i++) begin
        mem[wr_idx[i]] <= data_in_0[i];
      end
    end
  end

endmodule
